// File: rtl/gamepad_key_ctrl.sv
// Gamepad key controller: synchronise and debounce six keys, queue press/release events on a valid/ready FIFO, drive status LEDs.
// Optional auto-repeat of held keys is built when GAMEPAD_REPEAT_EN is defined.
module gamepad_key_ctrl #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FIFO_DEPTH      = 8,
   parameter int REPEAT_DELAY    = 256,
   parameter int REPEAT_PERIOD   = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       key_up_i,
   input  logic       key_down_i,
   input  logic       key_right_i,
   input  logic       key_left_i,
   input  logic       key_a_i,
   input  logic       key_b_i,
   output logic       evt_valid_o,
   input  logic       evt_ready_i,
   output logic [2:0] evt_key_o,
   output logic       evt_press_o,
   output logic       evt_repeat_o,
   output logic [5:0] key_state_o,
   output logic       overflow_o,
   input  logic       clr_overflow_i,
   output logic       led1_o,
   output logic       led2_o
);
   localparam int NKEYS = 6;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   typedef struct packed {
      logic       rpt;
      logic       press;
      logic [2:0] key;
   } evt_t;

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 6 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("gamepad_key_ctrl: illegal parameter set");
   end

   logic [NKEYS-1:0]                  raw, synced;
   logic [SYNC_STAGES-1:0][NKEYS-1:0] sync_q;
   logic [NKEYS-1:0][CNT_W-1:0]       db_cnt_q;
   logic [NKEYS-1:0]                  stable_q, flip, rpt_fire;
   logic [NKEYS-1:0]                  pend_q, pend_press_q, pend_rpt_q;
   logic [NKEYS-1:0]                  new_evt, new_press, new_rpt, pushed, collide;
   logic [2:0]                        push_idx;
   logic                              push, pop, full, empty;
   evt_t                              push_evt, head;
   evt_t                              fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]                    wr_ptr_q, rd_ptr_q;

   assign raw    = {key_b_i, key_a_i, key_left_i, key_right_i, key_down_i, key_up_i};
   assign synced = sync_q[SYNC_STAGES-1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   always_comb begin
      flip = '0;
      for (int k = 0; k < NKEYS; k++)
         flip[k] = (synced[k] != stable_q[k]) && (db_cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         db_cnt_q <= '0;
         stable_q <= '0;
      end else begin
         for (int k = 0; k < NKEYS; k++) begin
            if (synced[k] == stable_q[k] || flip[k]) db_cnt_q[k] <= '0;
            else                                     db_cnt_q[k] <= db_cnt_q[k] + CNT_W'(1);
            if (flip[k]) stable_q[k] <= synced[k];
         end
      end
   end

`ifdef GAMEPAD_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
   logic [NKEYS-1:0][HOLD_W-1:0] hold_cnt_q;
   logic [NKEYS-1:0]             hold_periodic_q;

   // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; a release never repeats.
   always_comb begin
      rpt_fire = '0;
      for (int k = 0; k < NKEYS; k++)
         rpt_fire[k] = stable_q[k] && !flip[k] &&
                       (hold_cnt_q[k] == (hold_periodic_q[k] ? HOLD_W'(REPEAT_PERIOD - 1)
                                                             : HOLD_W'(REPEAT_DELAY - 1)));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_cnt_q      <= '0;
         hold_periodic_q <= '0;
      end else begin
         for (int k = 0; k < NKEYS; k++) begin
            if (flip[k] || !stable_q[k]) begin
               hold_cnt_q[k]      <= '0;
               hold_periodic_q[k] <= 1'b0;
            end else if (rpt_fire[k]) begin
               hold_cnt_q[k]      <= '0;
               hold_periodic_q[k] <= 1'b1;
            end else begin
               hold_cnt_q[k] <= hold_cnt_q[k] + HOLD_W'(1);
            end
         end
      end
   end
`else
   assign rpt_fire = '0;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      push_idx  = '0;
      pushed    = '0;
      new_evt   = '0;
      new_press = '0;
      new_rpt   = '0;
      collide   = '0;
      for (int k = NKEYS - 1; k >= 0; k--)
         if (pend_q[k]) push_idx = 3'(k);
      push           = (|pend_q) && (!full || pop);
      push_evt.rpt   = pend_rpt_q[push_idx];
      push_evt.press = pend_press_q[push_idx];
      push_evt.key   = push_idx;
      for (int k = 0; k < NKEYS; k++) begin
         pushed[k]    = push && (push_idx == 3'(k));
         new_evt[k]   = flip[k] || rpt_fire[k];
         new_press[k] = flip[k] ? synced[k] : 1'b1;
         new_rpt[k]   = !flip[k] && rpt_fire[k];
         collide[k]   = new_evt[k] && pend_q[k] && !pushed[k];
      end
   end

   // A colliding event is dropped; the older pending event survives.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q       <= '0;
         pend_press_q <= '0;
         pend_rpt_q   <= '0;
      end else begin
         for (int k = 0; k < NKEYS; k++) begin
            if (new_evt[k] && !collide[k]) begin
               pend_q[k]       <= 1'b1;
               pend_press_q[k] <= new_press[k];
               pend_rpt_q[k]   <= new_rpt[k];
            end else if (pushed[k]) begin
               pend_q[k] <= 1'b0;
            end
         end
      end
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop   = !empty && evt_ready_i;

   // NOTE: event storage is deliberately not reset; the empty gate on the head keeps outputs clean.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_evt;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_o <= 1'b0;
         led1_o     <= 1'b0;
         led2_o     <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (|collide)           overflow_o <= 1'b1;
         else if (clr_overflow_i) overflow_o <= 1'b0;
         led1_o <= |stable_q;
         led2_o <= overflow_o;
      end
   end

   assign head         = empty ? '0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
   assign evt_valid_o  = !empty;
   assign evt_key_o    = head.key;
   assign evt_press_o  = head.press;
   assign evt_repeat_o = head.rpt;
   assign key_state_o  = stable_q;

endmodule

// File: tb/tb_gamepad_key_ctrl.sv
// Self-checking bench for gamepad_key_ctrl: window-based event model compared every cycle plus directed literal checks.
// Define GAMEPAD_REPEAT_EN for both files to exercise auto-repeat instead of the overflow scenario.
`timescale 1ns/1ps
module tb_gamepad_key_ctrl;
   localparam int SYNC    = 2;
   localparam int DEB     = 6;
   localparam int DEPTH   = 4;
   localparam int RDELAY  = 20;
   localparam int RPERIOD = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] keys;
   logic       ready, clr;
   logic       evt_valid, evt_press, evt_repeat, overflow, led1, led2;
   logic [2:0] evt_key;
   logic [5:0] key_state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gamepad_key_ctrl #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH),
      .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .key_up_i(keys[0]), .key_down_i(keys[1]), .key_right_i(keys[2]),
      .key_left_i(keys[3]), .key_a_i(keys[4]), .key_b_i(keys[5]),
      .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_key_o(evt_key),
      .evt_press_o(evt_press), .evt_repeat_o(evt_repeat), .key_state_o(key_state),
      .overflow_o(overflow), .clr_overflow_i(clr), .led1_o(led1), .led2_o(led2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a key's level is accepted once its synchronised samples have differed from
   // the accepted level for DEB consecutive cycles; events wait per key, then queue in order.
   typedef struct packed {
      logic       rpt;
      logic       press;
      logic [2:0] key;
   } m_evt_t;

   m_evt_t     m_fifo[$];
   logic [5:0] m_hist[$];
   logic [5:0] m_stable, m_pend, m_pend_press, m_pend_rpt;
   logic       m_ovf, m_led1, m_led2;
   int         m_held[6];

   task automatic model_reset();
      m_fifo.delete();
      m_hist.delete();
      repeat (SYNC + DEB - 1) m_hist.push_back(6'b0);
      m_stable = '0; m_pend = '0; m_pend_press = '0; m_pend_rpt = '0;
      m_ovf = 1'b0; m_led1 = 1'b0; m_led2 = 1'b0;
      for (int k = 0; k < 6; k++) m_held[k] = 0;
   endtask

   task automatic model_step();
      logic [5:0] flips, fire;
      int         push_k;
      bit         do_pop, ovf_set;
      m_evt_t     e;
      flips = '0; fire = '0; push_k = -1; ovf_set = 1'b0;
      do_pop = (m_fifo.size() != 0) && ready;
      for (int k = 5; k >= 0; k--) if (m_pend[k]) push_k = k;
      if (push_k >= 0 && m_fifo.size() >= DEPTH && !do_pop) push_k = -1;
      // m_hist holds the oldest samples first; entries 0..DEB-1 are what the debouncer has seen.
      for (int k = 0; k < 6; k++) begin
         flips[k] = 1'b1;
         for (int j = 0; j < DEB; j++) if (m_hist[j][k] == m_stable[k]) flips[k] = 1'b0;
      end
`ifdef GAMEPAD_REPEAT_EN
      for (int k = 0; k < 6; k++) begin
         if (m_stable[k] && !flips[k]) begin
            m_held[k]++;
            if (m_held[k] >= RDELAY && (m_held[k] - RDELAY) % RPERIOD == 0) fire[k] = 1'b1;
         end else begin
            m_held[k] = 0;
         end
      end
`endif
      m_led1 = |m_stable;
      m_led2 = m_ovf;
      if (do_pop) void'(m_fifo.pop_front());
      if (push_k >= 0) begin
         e.rpt = m_pend_rpt[push_k]; e.press = m_pend_press[push_k]; e.key = 3'(push_k);
         m_fifo.push_back(e);
      end
      for (int k = 0; k < 6; k++) begin
         if (flips[k] || fire[k]) begin
            if (m_pend[k] && k != push_k) ovf_set = 1'b1;
            else begin
               m_pend[k]       = 1'b1;
               m_pend_press[k] = flips[k] ? !m_stable[k] : 1'b1;
               m_pend_rpt[k]   = !flips[k];
            end
         end else if (k == push_k) begin
            m_pend[k] = 1'b0;
         end
      end
      if (ovf_set)  m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_stable = m_stable ^ flips;
      m_hist.push_back(keys);
      void'(m_hist.pop_front());
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   always @(negedge clk) begin
      check("cyc_valid", evt_valid, m_fifo.size() != 0);
      if (m_fifo.size() != 0) begin
         check("cyc_key", evt_key, m_fifo[0].key);
         check("cyc_press", evt_press, m_fifo[0].press);
         check("cyc_repeat", evt_repeat, m_fifo[0].rpt);
      end
      check("cyc_state", key_state, m_stable);
      check("cyc_ovf", overflow, m_ovf);
      check("cyc_led1", led1, m_led1);
      check("cyc_led2", led2, m_led2);
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      keys = '0; ready = 1'b0; clr = 1'b0; rst = 1'b1;
      edges(3);
      check("rst_valid", evt_valid, 0);
      check("rst_state", key_state, 0);
      check("rst_ovf", overflow, 0);
      check("rst_leds", {led2, led1}, 0);
      rst = 1'b0;
      edges(2);

      // Single press of key a, latency 9 edges, then release
      keys[4] = 1'b1;
      edges(8);
      check("a_state", key_state, 6'b010000);
      check("a_valid_early", evt_valid, 0);
      check("a_led1_early", led1, 0);
      edges(1);
      check("a_valid", evt_valid, 1);
      check("a_key", evt_key, 4);
      check("a_press", evt_press, 1);
      check("a_led1", led1, 1);
      ready = 1'b1;
      edges(1);
      check("a_popped", evt_valid, 0);
      keys[4] = 1'b0;
      edges(9);
      check("a_rel_valid", evt_valid, 1);
      check("a_rel_press", evt_press, 0);
      check("a_rel_state", key_state, 0);
      edges(1);
      check("a_rel_popped", evt_valid, 0);

      // Glitch shorter than the debounce window
      keys[0] = 1'b1;
      edges(5);
      keys[0] = 1'b0;
      edges(12);
      check("glitch_state", key_state, 0);
      check("glitch_valid", evt_valid, 0);

      // Simultaneous presses come out lowest index first
      keys[0] = 1'b1; keys[1] = 1'b1; keys[5] = 1'b1;
      edges(9);
      check("multi0_key", evt_key, 0);
      check("multi0_press", evt_press, 1);
      edges(1);
      check("multi1_key", evt_key, 1);
      edges(1);
      check("multi2_key", evt_key, 5);
      check("multi2_valid", evt_valid, 1);
      edges(1);
      check("multi_empty", evt_valid, 0);
      check("multi_state", key_state, 6'b100011);
      keys = '0;
      edges(14);

`ifndef GAMEPAD_REPEAT_EN
      // Fill the FIFO, leave key 0 pending, then collide on it
      ready = 1'b0;
      keys[1] = 1'b1; edges(2);
      keys[2] = 1'b1; edges(2);
      keys[3] = 1'b1; edges(2);
      keys[4] = 1'b1; edges(2);
      keys[0] = 1'b1; edges(12);
      check("full_head_key", evt_key, 1);
      check("full_valid", evt_valid, 1);
      check("full_ovf", overflow, 0);
      check("full_state", key_state, 6'b011111);
      keys[0] = 1'b0;
      edges(8);
      check("coll_ovf", overflow, 1);
      check("coll_led2_early", led2, 0);
      check("coll_state", key_state, 6'b011110);
      edges(1);
      check("coll_led2", led2, 1);
      clr = 1'b1;
      edges(1);
      clr = 1'b0;
      check("clr_ovf", overflow, 0);
      keys[0] = 1'b1;
      edges(7);
      clr = 1'b1;
      edges(1);
      check("set_wins_ovf", overflow, 1);
      edges(1);
      check("clr_again_ovf", overflow, 0);
      clr = 1'b0;
      ready = 1'b1;
      keys = '0;
      edges(30);
`endif

      // Reset mid-debounce with two queued events
      ready = 1'b0;
      keys[1] = 1'b1; keys[2] = 1'b1;
      edges(10);
      check("pre_rst_valid", evt_valid, 1);
      keys[5] = 1'b1;
      edges(4);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", evt_valid, 0);
      check("mid_rst_evt", {evt_key, evt_press, evt_repeat}, 0);
      check("mid_rst_state", key_state, 0);
      check("mid_rst_misc", {overflow, led2, led1}, 0);
      edges(1);
      rst = 1'b0;
      edges(8);
      check("post_rst_state", key_state, 6'b100110);
      check("post_rst_early", evt_valid, 0);
      edges(1);
      check("post_rst_valid", evt_valid, 1);
      check("post_rst_key", evt_key, 1);
      check("post_rst_press", evt_press, 1);
      ready = 1'b1;
      keys = '0;
      edges(30);

`ifdef GAMEPAD_REPEAT_EN
      // Hold key b for 50 cycles: press, three repeats, release
      keys[5] = 1'b1;
      edges(9);
      check("rpt_press_key", evt_key, 5);
      check("rpt_press_rep", evt_repeat, 0);
      for (int i = 0; i < 3; i++) begin
         edges(i == 0 ? 20 : 10);
         check("rpt_valid", evt_valid, 1);
         check("rpt_key", evt_key, 5);
         check("rpt_flag", {evt_press, evt_repeat}, 2'b11);
      end
      edges(1);
      keys[5] = 1'b0;
      edges(9);
      check("rpt_rel_valid", evt_valid, 1);
      check("rpt_rel_flag", {evt_press, evt_repeat}, 2'b00);
      edges(5);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gamepad_key_ctrl.md
Name: gamepad_key_ctrl

Overview:
- Downstream consumer of the gamepad model's six key outputs. Synchronises and debounces each key, then converts stable edges into press/release events.
- Events are buffered in a small FIFO and presented on a valid/ready stream to the game logic or a CPU.
- Drives the gamepad's two status LED inputs: held-key indication and overflow.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per key input (min 2).
- DEBOUNCE_CYCLES, 16, consecutive cycles a new level must persist before it is accepted (min 6).
- FIFO_DEPTH, 8, event FIFO entries (power of 2, min 2).
- REPEAT_DELAY, 256, cycles a key is held before auto-repeat starts (used only with GAMEPAD_REPEAT_EN).
- REPEAT_PERIOD, 64, cycles between auto-repeat events (used only with GAMEPAD_REPEAT_EN).

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous reset, active-high.
- key_up_i, key_down_i, key_right_i, key_left_i, key_a_i, key_b_i  in  1 each  raw key levels, asynchronous.
- evt_valid_o  out  1  FIFO head valid.
- evt_ready_i  in  1  consumer accepts head.
- evt_key_o  out  3  key index: up=0, down=1, right=2, left=3, a=4, b=5.
- evt_press_o  out  1  1=press, 0=release.
- evt_repeat_o  out  1  event is an auto-repeat.
- key_state_o  out  6  debounced levels, bit = key index.
- overflow_o  out  1  sticky: an event was lost.
- clr_overflow_i  in  1  clears overflow_o.
- led1_o  out  1  to gamepad led1_i.
- led2_o  out  1  to gamepad led2_i.

Behaviour:
- Reset (async):
  - All outputs 0.
  - Sync chains, stable states, counters, pending flags, FIFO pointers cleared.
  - All keys read as released; no events generated on release from reset.
- Synchroniser: SYNC_STAGES flops per key.
- Debounce, per key:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - Counter cleared whenever the synced level equals the stable level.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES, the stable level flips, the counter clears, and that key's pending flag is set with press = new level.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
- Arbiter:
  - Each cycle, the lowest-index pending key is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - The pushed key's pending flag clears on push.
  - One push per cycle.
- Pending collision: an edge on a key whose pending flag is still set drops the new event and sets overflow_o. The pending event is kept.
- FIFO:
  - Entry is {repeat, press, key[2:0]}.
  - evt_valid_o = !empty; the head is stable while valid && !ready.
  - Pop on evt_valid_o && evt_ready_i.
  - Pointers wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
- Latency: with an empty FIFO and no contention, evt_valid_o rises SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges after the first edge that samples the new raw level (defaults: 19).
- overflow_o:
  - Set on a pending collision.
  - Cleared by clr_overflow_i.
  - If set and clear occur in the same cycle, set wins.
- LEDs (registered, 1-cycle delay):
  - led1_o = |key_state_o.
  - led2_o = overflow_o.
- key_state_o updates on the same edge as the stable level.

Optional Feature:
- Macro: GAMEPAD_REPEAT_EN.
- Defined:
  - Per-key hold counter starts when the stable level becomes pressed.
  - After REPEAT_DELAY cycles held, and then every REPEAT_PERIOD cycles, the key's pending flag is set with press=1, repeat=1.
  - Collisions follow the same rule as edges.
  - Release clears the hold counter.
- Undefined:
  - No hold counters.
  - evt_repeat_o is tied 0; the repeat bit still occupies the FIFO entry, but the input is constant 0.

Test Plan (bench uses DEBOUNCE_CYCLES=6, FIFO_DEPTH=4, SYNC_STAGES=2):
- key_a_i 0→1, held -> after 9 edges: evt_valid_o=1, evt_key_o=4, evt_press_o=1; key_state_o=6'b010000; led1_o=1 one cycle later.
- key_up_i pulse of 5 cycles -> no event, key_state_o stays 0.
- Up, down and b rise in the same cycle; evt_ready_i=1 -> events in order keys 0, 1, 5 on consecutive cycles, all press=1.
- evt_ready_i=0; 5 distinct presses then key 0 released -> FIFO holds 4 events, the 5th is pending; the key 0 release with key 0 pending sets overflow_o=1 and led2_o=1; clr_overflow_i clears it unless a collision occurs in the same cycle.
- rst_i asserted mid-debounce, with the FIFO holding 2 entries -> all outputs 0 immediately; after release of reset, a held key produces a fresh press event 9 edges later.
- With GAMEPAD_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10, key_b held 50 cycles -> one press, then repeats (repeat=1, key=5) at hold cycles 20, 30, 40; release produces press=0, repeat=0.
